// File: rtl/tcp_rx_engine.sv
// tcp_rx_engine: receive-side TCP header processing.
// CAM lookup, flow install with SYN-ACK, and state read-modify-write.
package tcp_rx_pkg;

  localparam int TCP_FIN = 0;
  localparam int TCP_SYN = 1;
  localparam int TCP_RST = 2;
  localparam int TCP_PSH = 3;
  localparam int TCP_ACK = 4;

  localparam logic [1:0] SCHED_NOP = 2'd0;
  localparam logic [1:0] SCHED_SET = 2'd1;
  localparam logic [1:0] SCHED_CLR = 2'd2;

  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [3:0]  data_offset;
    logic [3:0]  rsvd;
    logic [7:0]  flags;
    logic [15:0] win_size;
    logic [15:0] chksum;
    logic [15:0] urg_ptr;
  } tcp_pkt_hdr;

  typedef struct packed {
    logic [31:0] payload_addr;
    logic [15:0] payload_len;
  } smol_payload_buf_struct;

  typedef struct packed {
    logic [31:0] host_ip;
    logic [31:0] dest_ip;
    logic [15:0] host_port;
    logic [15:0] dest_port;
  } four_tuple_struct;

  typedef struct packed {
    logic [7:0]  flowid;
    logic [1:0]  rt_pend_set_clear;
    logic [1:0]  ack_pend_set_clear;
    logic [1:0]  data_pend_set_clear;
    logic [31:0] rt_timestamp;
    logic [31:0] ack_timestamp;
  } sched_cmd_struct;

endpackage

module tcp_rx_engine
  import tcp_rx_pkg::*;
#(
  parameter int          FLOWID_W      = 3,
  parameter int          RX_PTR_W      = 12,
  parameter int          TX_PTR_W      = 12,
  parameter logic [31:0] ISN           = 32'hff,
  parameter int          DUPACK_THRESH = 3,
  localparam int         DUP_W = $clog2(DUPACK_THRESH + 1),
  localparam int         FS_W  = 96 + 2 * (RX_PTR_W + 1) + DUP_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_hdr_val,
  output logic                  rx_hdr_rdy,
  input  logic [31:0]           rx_src_ip,
  input  logic [31:0]           rx_dst_ip,
  input  tcp_pkt_hdr            rx_tcp_hdr,
  input  smol_payload_buf_struct rx_payload_entry,
  output four_tuple_struct      cam_lookup_tag,
  input  logic                  cam_lookup_hit,
  input  logic [FLOWID_W-1:0]   cam_lookup_flowid,
  input  logic                  flowid_avail,
  input  logic [FLOWID_W-1:0]   flowid_alloc_flowid,
  output logic                  flowid_alloc_req,
  output logic                  state_rd_val,
  output logic [FLOWID_W-1:0]   state_rd_addr,
  input  logic [FS_W-1:0]       state_rd_data,
  output logic                  state_wr_val,
  output logic [FLOWID_W-1:0]   state_wr_addr,
  output logic [FS_W-1:0]       state_wr_data,
  output logic                  tx_head_wr_val,
  output logic [TX_PTR_W:0]     tx_head_wr_data,
  output logic                  pkt_accept_val,
  output logic [FLOWID_W-1:0]   pkt_accept_flowid,
  output smol_payload_buf_struct pkt_accept_entry,
  output logic                  sched_cmd_val,
  output sched_cmd_struct       sched_cmd,
  output logic                  new_flow_val,
  output logic [FLOWID_W-1:0]   new_flow_flowid,
  output four_tuple_struct      new_flow_entry,
  output logic [FS_W-1:0]       new_flow_state,
  output logic                  synack_val,
  input  logic                  synack_rdy,
  output tcp_pkt_hdr            synack_hdr,
  output logic [31:0]           synack_src_ip,
  output logic [31:0]           synack_dst_ip,
  output logic [FLOWID_W-1:0]   synack_flowid,
  output logic                  flow_close_val,
  output logic [FLOWID_W-1:0]   flow_close_flowid,
  output logic [31:0]           drop_cnt
);

  typedef struct packed {
    logic [31:0]      their_ack;
    logic [31:0]      our_ack;
    logic [31:0]      our_seq;
    logic [RX_PTR_W:0] rx_head;
    logic [RX_PTR_W:0] rx_tail;
    logic [DUP_W-1:0] dup_cnt;
    logic             fin_rcvd;
  } fs_t;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, NEW_FLOW, SYNACK, RD, RD_WAIT, CALC, WR
  } state_e;

  localparam logic [RX_PTR_W:0] RX_SIZE = (RX_PTR_W + 1)'(1) << RX_PTR_W;
  localparam logic [DUP_W-1:0]  DUP_MAX = DUP_W'(DUPACK_THRESH);

  state_e                 state, state_nxt;
  logic [31:0]            src_ip_r, dst_ip_r;
  tcp_pkt_hdr             hdr_r;
  smol_payload_buf_struct entry_r;
  logic [FLOWID_W-1:0]    flowid_r;
  fs_t                    fs_r, wr_fs_r, c_fs, nf_fs;
  logic                   wr_en_r, close_r, acc_r, txh_r;
  logic [1:0]             rt_r, ack_r, data_r;
  logic                   c_wr, c_close, c_acc, c_txh, c_drop;
  logic [1:0]             c_rt, c_ack, c_data;
  logic                   lk_alloc, drop_inc;
  logic [15:0]            len;
  logic [RX_PTR_W:0]      used, free;
  logic [31:0]            d_ack, d_seq;
  logic                   is_rst, is_fin, is_ack, in_seq, accept;
  logic                   new_ack, dup_ack;
  logic                   unused_hdr;

  assign unused_hdr = ^{hdr_r.data_offset, hdr_r.rsvd, hdr_r.flags[7:5],
                        hdr_r.flags[TCP_PSH], hdr_r.win_size,
                        hdr_r.chksum, hdr_r.urg_ptr};

  assign cam_lookup_tag = '{host_ip: dst_ip_r, dest_ip: src_ip_r,
                            host_port: hdr_r.dst_port,
                            dest_port: hdr_r.src_port};
  assign new_flow_entry    = cam_lookup_tag;
  assign new_flow_flowid   = flowid_r;
  assign new_flow_state    = nf_fs;
  assign synack_flowid     = flowid_r;
  assign synack_src_ip     = dst_ip_r;
  assign synack_dst_ip     = src_ip_r;
  assign state_rd_addr     = flowid_r;
  assign state_wr_addr     = flowid_r;
  assign state_wr_data     = wr_fs_r;
  assign tx_head_wr_data   = hdr_r.ack_num[TX_PTR_W:0];
  assign pkt_accept_flowid = flowid_r;
  assign pkt_accept_entry  = entry_r;
  assign flow_close_flowid = flowid_r;
  assign sched_cmd = '{flowid: 8'(flowid_r), rt_pend_set_clear: rt_r,
                       ack_pend_set_clear: ack_r,
                       data_pend_set_clear: data_r,
                       rt_timestamp: '0, ack_timestamp: '0};

  assign lk_alloc = hdr_r.flags[TCP_SYN] & ~hdr_r.flags[TCP_ACK]
                  & flowid_avail;

  // Fresh flow state and SYN-ACK header derived from the captured SYN.
  always_comb begin
    nf_fs           = '0;
    nf_fs.their_ack = hdr_r.seq_num + 32'd1;
    nf_fs.our_ack   = ISN + 32'd1;
    nf_fs.our_seq   = ISN + 32'd1;
    synack_hdr             = '0;
    synack_hdr.src_port    = hdr_r.dst_port;
    synack_hdr.dst_port    = hdr_r.src_port;
    synack_hdr.seq_num     = ISN;
    synack_hdr.ack_num     = hdr_r.seq_num + 32'd1;
    synack_hdr.data_offset = 4'd5;
    synack_hdr.flags[TCP_SYN] = 1'b1;
    synack_hdr.flags[TCP_ACK] = 1'b1;
    synack_hdr.win_size    = 16'hffff;
  end

  // Receive-window, sequence and ACK classification of the packet.
  always_comb begin
    len     = entry_r.payload_len;
    is_rst  = hdr_r.flags[TCP_RST];
    is_fin  = hdr_r.flags[TCP_FIN];
    is_ack  = hdr_r.flags[TCP_ACK];
    used    = fs_r.rx_tail - fs_r.rx_head;
    free    = RX_SIZE - used;
    in_seq  = hdr_r.seq_num == fs_r.their_ack;
    accept  = in_seq && (32'(len) <= 32'(free));
    d_ack   = hdr_r.ack_num - fs_r.our_ack;
    d_seq   = hdr_r.ack_num - fs_r.our_seq;
    new_ack = is_ack && !d_ack[31] && (d_ack != '0)
            && (d_seq[31] || d_seq == '0);
    dup_ack = is_ack && (hdr_r.ack_num == fs_r.our_ack)
            && (len == '0) && (hdr_r.ack_num != fs_r.our_seq);
  end

  // Next flow state and side-effects computed from the read state.
  always_comb begin
    c_fs    = fs_r;
    c_wr    = 1'b1;
    c_close = 1'b0;
    c_acc   = 1'b0;
    c_txh   = 1'b0;
    c_drop  = 1'b0;
    c_rt    = SCHED_NOP;
    c_ack   = SCHED_NOP;
    c_data  = SCHED_NOP;
    if (is_rst) begin
      c_wr    = 1'b0;
      c_close = in_seq;
      c_drop  = !in_seq;
    end else begin
      if ((len != '0) || is_fin) begin
        c_ack = SCHED_SET;
        if (accept) begin
          c_fs.their_ack = fs_r.their_ack + 32'(len)
                         + (is_fin ? 32'd1 : 32'd0);
          c_fs.rx_tail = fs_r.rx_tail + (RX_PTR_W + 1)'(len);
          c_acc        = len != '0;
          if (len != '0) c_data = SCHED_SET;
          if (is_fin) c_fs.fin_rcvd = 1'b1;
        end
      end
      if (new_ack) begin
        c_fs.our_ack = hdr_r.ack_num;
        c_fs.dup_cnt = '0;
        c_txh        = 1'b1;
        c_rt         = SCHED_SET;
      end else if (dup_ack && fs_r.dup_cnt != DUP_MAX) begin
        c_fs.dup_cnt = fs_r.dup_cnt + DUP_W'(1);
        if (fs_r.dup_cnt == DUP_MAX - DUP_W'(1)) c_rt = SCHED_SET;
      end
    end
  end

  // FSM next state and per-state strobes.
  always_comb begin
    state_nxt        = state;
    rx_hdr_rdy       = 1'b0;
    flowid_alloc_req = 1'b0;
    state_rd_val     = 1'b0;
    new_flow_val     = 1'b0;
    synack_val       = 1'b0;
    state_wr_val     = 1'b0;
    tx_head_wr_val   = 1'b0;
    pkt_accept_val   = 1'b0;
    sched_cmd_val    = 1'b0;
    flow_close_val   = 1'b0;
    drop_inc         = 1'b0;
    unique case (state)
      IDLE: begin
        rx_hdr_rdy = 1'b1;
        if (rx_hdr_val) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (cam_lookup_hit) begin
          state_nxt = RD;
        end else if (lk_alloc) begin
          flowid_alloc_req = 1'b1;
          state_nxt        = NEW_FLOW;
        end else begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      NEW_FLOW: begin
        new_flow_val = 1'b1;
        state_nxt    = SYNACK;
      end
      SYNACK: begin
        synack_val = 1'b1;
        if (synack_rdy) state_nxt = IDLE;
      end
      RD: begin
        state_rd_val = 1'b1;
        state_nxt    = RD_WAIT;
      end
      RD_WAIT: state_nxt = CALC;
      CALC: begin
        drop_inc  = c_drop;
        state_nxt = WR;
      end
      WR: begin
        state_wr_val   = wr_en_r;
        sched_cmd_val  = wr_en_r;
        tx_head_wr_val = txh_r;
        pkt_accept_val = acc_r;
        flow_close_val = close_r;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Saturating count of dropped packets.
  always_ff @(posedge clk) begin
    if (rst) drop_cnt <= '0;
    else if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
  end

  // Packet capture, flow ID latch, state read and CALC result registers.
  always_ff @(posedge clk) begin
    if (state == IDLE && rx_hdr_val) begin
      src_ip_r <= rx_src_ip;
      dst_ip_r <= rx_dst_ip;
      hdr_r    <= rx_tcp_hdr;
      entry_r  <= rx_payload_entry;
    end
    if (state == LOOKUP) begin
      if (cam_lookup_hit) flowid_r <= cam_lookup_flowid;
      else if (lk_alloc)  flowid_r <= flowid_alloc_flowid;
    end
    if (state == RD_WAIT) fs_r <= state_rd_data;
    if (state == CALC) begin
      wr_fs_r <= c_fs;
      wr_en_r <= c_wr;
      close_r <= c_close;
      acc_r   <= c_acc;
      txh_r   <= c_txh;
      rt_r    <= c_rt;
      ack_r   <= c_ack;
      data_r  <= c_data;
    end
  end

endmodule

// File: tb/tb_tcp_rx_engine.sv
// tb_tcp_rx_engine: directed tests for tcp_rx_engine.
// Hand-computed expectations, one task per scenario.
module tb_tcp_rx_engine;
  import tcp_rx_pkg::*;

  localparam int FW   = 3;
  localparam int FS_W = 125;
  localparam logic [31:0] IP_A = 32'h0a00_0001;
  localparam logic [31:0] IP_B = 32'h0a00_0002;
  localparam logic [7:0] F_FIN = 8'h01;
  localparam logic [7:0] F_SYN = 8'h02;
  localparam logic [7:0] F_RST = 8'h04;
  localparam logic [7:0] F_PSH = 8'h08;
  localparam logic [7:0] F_ACK = 8'h10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_hdr_val = 1'b0;
  logic rx_hdr_rdy;
  logic [31:0] rx_src_ip = '0, rx_dst_ip = '0;
  tcp_pkt_hdr rx_tcp_hdr = '0;
  smol_payload_buf_struct rx_payload_entry = '0;
  four_tuple_struct cam_lookup_tag;
  logic cam_lookup_hit = 1'b0;
  logic [FW-1:0] cam_lookup_flowid = '0;
  logic flowid_avail = 1'b0;
  logic [FW-1:0] flowid_alloc_flowid = '0;
  logic flowid_alloc_req;
  logic state_rd_val;
  logic [FW-1:0] state_rd_addr;
  logic [FS_W-1:0] state_rd_data = '0;
  logic state_wr_val;
  logic [FW-1:0] state_wr_addr;
  logic [FS_W-1:0] state_wr_data;
  logic tx_head_wr_val;
  logic [12:0] tx_head_wr_data;
  logic pkt_accept_val;
  logic [FW-1:0] pkt_accept_flowid;
  smol_payload_buf_struct pkt_accept_entry;
  logic sched_cmd_val;
  sched_cmd_struct sched_cmd;
  logic new_flow_val;
  logic [FW-1:0] new_flow_flowid;
  four_tuple_struct new_flow_entry;
  logic [FS_W-1:0] new_flow_state;
  logic synack_val;
  logic synack_rdy = 1'b0;
  tcp_pkt_hdr synack_hdr;
  logic [31:0] synack_src_ip, synack_dst_ip;
  logic [FW-1:0] synack_flowid;
  logic flow_close_val;
  logic [FW-1:0] flow_close_flowid;
  logic [31:0] drop_cnt;

  int checks = 0;
  int errs = 0;

  tcp_rx_engine dut (
    .clk(clk), .rst(rst),
    .rx_hdr_val(rx_hdr_val), .rx_hdr_rdy(rx_hdr_rdy),
    .rx_src_ip(rx_src_ip), .rx_dst_ip(rx_dst_ip),
    .rx_tcp_hdr(rx_tcp_hdr), .rx_payload_entry(rx_payload_entry),
    .cam_lookup_tag(cam_lookup_tag), .cam_lookup_hit(cam_lookup_hit),
    .cam_lookup_flowid(cam_lookup_flowid),
    .flowid_avail(flowid_avail),
    .flowid_alloc_flowid(flowid_alloc_flowid),
    .flowid_alloc_req(flowid_alloc_req),
    .state_rd_val(state_rd_val), .state_rd_addr(state_rd_addr),
    .state_rd_data(state_rd_data),
    .state_wr_val(state_wr_val), .state_wr_addr(state_wr_addr),
    .state_wr_data(state_wr_data),
    .tx_head_wr_val(tx_head_wr_val),
    .tx_head_wr_data(tx_head_wr_data),
    .pkt_accept_val(pkt_accept_val),
    .pkt_accept_flowid(pkt_accept_flowid),
    .pkt_accept_entry(pkt_accept_entry),
    .sched_cmd_val(sched_cmd_val), .sched_cmd(sched_cmd),
    .new_flow_val(new_flow_val), .new_flow_flowid(new_flow_flowid),
    .new_flow_entry(new_flow_entry), .new_flow_state(new_flow_state),
    .synack_val(synack_val), .synack_rdy(synack_rdy),
    .synack_hdr(synack_hdr), .synack_src_ip(synack_src_ip),
    .synack_dst_ip(synack_dst_ip), .synack_flowid(synack_flowid),
    .flow_close_val(flow_close_val),
    .flow_close_flowid(flow_close_flowid),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [FS_W-1:0] mk(
    input logic [31:0] ta, input logic [31:0] oa,
    input logic [31:0] os, input logic [12:0] h,
    input logic [12:0] t, input logic [1:0] d, input logic f);
    return {ta, oa, os, h, t, d, f};
  endfunction

  function automatic logic [10:0] strobes();
    return {state_wr_val, sched_cmd_val, tx_head_wr_val,
            pkt_accept_val, flow_close_val, new_flow_val,
            synack_val, flowid_alloc_req, state_rd_val,
            rx_hdr_val, 1'b0};
  endfunction

  // Drive one header; returns at the negedge after the handshake.
  task automatic send_pkt(input logic [31:0] seq,
                          input logic [31:0] ack,
                          input logic [7:0] flags,
                          input logic [15:0] len);
    tcp_pkt_hdr h;
    int n;
    n = 0;
    @(negedge clk);
    while (!rx_hdr_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_hdr_rdy) begin
      checks++; errs++;
      $display("FAIL rdy_timeout got=0 exp=1");
    end
    h = '0;
    h.src_port = 16'd1000;
    h.dst_port = 16'd80;
    h.seq_num = seq;
    h.ack_num = ack;
    h.flags = flags;
    rx_tcp_hdr = h;
    rx_src_ip = IP_A;
    rx_dst_ip = IP_B;
    rx_payload_entry = '{payload_addr: 32'h100, payload_len: len};
    rx_hdr_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rx_hdr_val = 1'b0;
  endtask

  // Cycles (negedges after handshake) of state read and WR.
  task automatic wait_wr(output int rd_cyc, output int wr_cyc);
    bit done;
    done = 0;
    rd_cyc = 0;
    wr_cyc = 0;
    for (int n = 1; n <= 12 && !done; n++) begin
      if (state_rd_val) rd_cyc = n;
      if (state_wr_val || flow_close_val) begin
        wr_cyc = n;
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_hdr_rdy !== 1'b1) begin
      errs++; $display("FAIL reset_rdy got=%b exp=1", rx_hdr_rdy);
    end
    checks++;
    if (strobes() !== 11'd0) begin
      errs++; $display("FAIL reset_vals got=%b exp=0", strobes());
    end
    checks++;
    if (drop_cnt !== 32'd0) begin
      errs++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt);
    end
  endtask

  task automatic test_new_flow();
    four_tuple_struct et;
    logic [FS_W-1:0] es;
    cam_lookup_hit = 1'b0;
    flowid_avail = 1'b1;
    flowid_alloc_flowid = 3'd2;
    synack_rdy = 1'b0;
    send_pkt(32'h1234_5678, 32'd0, F_SYN, 16'd0);
    et = '{host_ip: IP_B, dest_ip: IP_A, host_port: 16'd80,
           dest_port: 16'd1000};
    checks++;
    if (cam_lookup_tag !== et) begin
      errs++; $display("FAIL nf_tag got=%h exp=%h", cam_lookup_tag, et);
    end
    checks++;
    if (flowid_alloc_req !== 1'b1) begin
      errs++; $display("FAIL nf_alloc got=%b exp=1", flowid_alloc_req);
    end
    @(negedge clk);
    es = mk(32'h1234_5679, 32'h100, 32'h100, 13'd0, 13'd0, 2'd0, 1'b0);
    checks++;
    if ({new_flow_val, new_flow_flowid} !== {1'b1, 3'd2}) begin
      errs++; $display("FAIL nf_val got=%b/%0d exp=1/2",
                       new_flow_val, new_flow_flowid);
    end
    checks++;
    if (new_flow_state !== es) begin
      errs++; $display("FAIL nf_state got=%h exp=%h", new_flow_state, es);
    end
    checks++;
    if (new_flow_entry !== et) begin
      errs++; $display("FAIL nf_entry got=%h exp=%h", new_flow_entry, et);
    end
    @(negedge clk);
    checks++;
    if ({synack_val, synack_hdr.seq_num, synack_hdr.ack_num,
         synack_hdr.flags} !== {1'b1, 32'hff, 32'h1234_5679, 8'h12}) begin
      errs++; $display("FAIL sa_hdr got=%b %h %h %h exp=1 ff 12345679 12",
                       synack_val, synack_hdr.seq_num,
                       synack_hdr.ack_num, synack_hdr.flags);
    end
    checks++;
    if ({synack_hdr.src_port, synack_hdr.dst_port, synack_src_ip,
         synack_dst_ip, synack_flowid} !==
        {16'd80, 16'd1000, IP_B, IP_A, 3'd2}) begin
      errs++; $display("FAIL sa_swap got=%0d %0d %h %h %0d",
                       synack_hdr.src_port, synack_hdr.dst_port,
                       synack_src_ip, synack_dst_ip, synack_flowid);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (synack_val !== 1'b1) begin
        errs++; $display("FAIL sa_hold%0d got=%b exp=1", i, synack_val);
      end
    end
    synack_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    synack_rdy = 1'b0;
    flowid_avail = 1'b0;
    checks++;
    if ({synack_val, rx_hdr_rdy} !== 2'b01) begin
      errs++; $display("FAIL sa_done got=%b%b exp=01",
                       synack_val, rx_hdr_rdy);
    end
  endtask

  task automatic test_accept();
    int rc, wc;
    logic [FS_W-1:0] es;
    cam_lookup_hit = 1'b1;
    cam_lookup_flowid = 3'd5;
    state_rd_data = mk(32'd1000, 32'd5000, 32'd5000, 13'd0, 13'd0,
                       2'd0, 1'b0);
    send_pkt(32'd1000, 32'd5000, F_ACK | F_PSH, 16'd100);
    wait_wr(rc, wc);
    checks++;
    if ({rc, wc} !== {32'd2, 32'd5}) begin
      errs++; $display("FAIL acc_lat got=rd%0d wr%0d exp=rd2 wr5", rc, wc);
    end
    es = mk(32'd1100, 32'd5000, 32'd5000, 13'd0, 13'd100, 2'd0, 1'b0);
    checks++;
    if ({state_wr_addr, state_wr_data} !== {3'd5, es}) begin
      errs++; $display("FAIL acc_data got=%h exp=%h", state_wr_data, es);
    end
    checks++;
    if ({pkt_accept_val, pkt_accept_flowid, pkt_accept_entry.payload_len,
         tx_head_wr_val} !== {1'b1, 3'd5, 16'd100, 1'b0}) begin
      errs++; $display("FAIL acc_side got=%b %0d %0d %b exp=1 5 100 0",
                       pkt_accept_val, pkt_accept_flowid,
                       pkt_accept_entry.payload_len, tx_head_wr_val);
    end
    checks++;
    if ({sched_cmd_val, sched_cmd.flowid, sched_cmd.ack_pend_set_clear,
         sched_cmd.data_pend_set_clear, sched_cmd.rt_pend_set_clear,
         sched_cmd.rt_timestamp} !==
        {1'b1, 8'd5, SCHED_SET, SCHED_SET, SCHED_NOP, 32'd0}) begin
      errs++; $display("FAIL acc_sched got=%b %h exp=1 set/set/nop",
                       sched_cmd_val, sched_cmd);
    end
    state_rd_data = mk(32'hffff_fff0, 32'd5000, 32'd5000, 13'd0, 13'd0,
                       2'd0, 1'b0);
    send_pkt(32'hffff_fff0, 32'd5000, F_ACK | F_FIN, 16'h20);
    wait_wr(rc, wc);
    es = mk(32'h11, 32'd5000, 32'd5000, 13'd0, 13'h20, 2'd0, 1'b1);
    checks++;
    if ({wc, state_wr_data} !== {32'd5, es}) begin
      errs++; $display("FAIL fin_wrap got=%0d %h exp=5 %h",
                       wc, state_wr_data, es);
    end
    checks++;
    if ({pkt_accept_val, sched_cmd.ack_pend_set_clear} !==
        {1'b1, SCHED_SET}) begin
      errs++; $display("FAIL fin_side got=%b %b exp=1 01",
                       pkt_accept_val, sched_cmd.ack_pend_set_clear);
    end
  endtask

  task automatic test_reject_wrap();
    int rc, wc;
    logic [FS_W-1:0] es;
    es = mk(32'd1000, 32'd5000, 32'd5000, 13'd0, 13'd4000, 2'd0, 1'b0);
    state_rd_data = es;
    send_pkt(32'd1000, 32'd5000, F_ACK, 16'd200);
    wait_wr(rc, wc);
    checks++;
    if ({wc, state_wr_data, pkt_accept_val} !== {32'd5, es, 1'b0}) begin
      errs++; $display("FAIL rej_data got=%0d %h %b exp=5 %h 0",
                       wc, state_wr_data, pkt_accept_val, es);
    end
    checks++;
    if ({sched_cmd_val, sched_cmd.ack_pend_set_clear,
         sched_cmd.data_pend_set_clear, sched_cmd.rt_pend_set_clear} !==
        {1'b1, SCHED_SET, SCHED_NOP, SCHED_NOP}) begin
      errs++; $display("FAIL rej_sched got=%b %b %b %b exp=1 01 00 00",
                       sched_cmd_val, sched_cmd.ack_pend_set_clear,
                       sched_cmd.data_pend_set_clear,
                       sched_cmd.rt_pend_set_clear);
    end
    state_rd_data = mk(32'd1000, 32'd5000, 32'd5000, 13'd8100, 13'd8190,
                       2'd0, 1'b0);
    send_pkt(32'd1000, 32'd5000, F_ACK, 16'd4);
    wait_wr(rc, wc);
    es = mk(32'd1004, 32'd5000, 32'd5000, 13'd8100, 13'd2, 2'd0, 1'b0);
    checks++;
    if ({wc, state_wr_data, pkt_accept_val} !== {32'd5, es, 1'b1}) begin
      errs++; $display("FAIL tail_wrap got=%0d %h %b exp=5 %h 1",
                       wc, state_wr_data, pkt_accept_val, es);
    end
  endtask

  task automatic test_dupack();
    int rc, wc;
    logic [FS_W-1:0] es;
    logic [1:0] d, ert;
    for (int i = 0; i < 4; i++) begin
      state_rd_data = mk(32'd1000, 32'd2000, 32'd3000, 13'd0, 13'd0,
                         2'(i), 1'b0);
      send_pkt(32'd1000, 32'd2000, F_ACK, 16'd0);
      wait_wr(rc, wc);
      d = (i < 3) ? 2'(i + 1) : 2'd3;
      ert = (i == 2) ? SCHED_SET : SCHED_NOP;
      es = mk(32'd1000, 32'd2000, 32'd3000, 13'd0, 13'd0, d, 1'b0);
      checks++;
      if ({wc, state_wr_data, sched_cmd.rt_pend_set_clear,
           tx_head_wr_val} !== {32'd5, es, ert, 1'b0}) begin
        errs++; $display("FAIL dup%0d got=%0d %h rt=%b txh=%b exp dup=%0d rt=%b",
                         i, wc, state_wr_data,
                         sched_cmd.rt_pend_set_clear, tx_head_wr_val,
                         d, ert);
      end
    end
    state_rd_data = mk(32'd1000, 32'd2000, 32'd3000, 13'd0, 13'd0,
                       2'd3, 1'b0);
    send_pkt(32'd1000, 32'd2500, F_ACK, 16'd0);
    wait_wr(rc, wc);
    es = mk(32'd1000, 32'd2500, 32'd3000, 13'd0, 13'd0, 2'd0, 1'b0);
    checks++;
    if ({wc, state_wr_data} !== {32'd5, es}) begin
      errs++; $display("FAIL newack_data got=%0d %h exp=5 %h",
                       wc, state_wr_data, es);
    end
    checks++;
    if ({tx_head_wr_val, tx_head_wr_data, sched_cmd.rt_pend_set_clear} !==
        {1'b1, 13'd2500, SCHED_SET}) begin
      errs++; $display("FAIL newack_txh got=%b %0d %b exp=1 2500 01",
                       tx_head_wr_val, tx_head_wr_data,
                       sched_cmd.rt_pend_set_clear);
    end
  endtask

  task automatic test_rst_drop();
    int rc, wc;
    cam_lookup_hit = 1'b0;
    flowid_avail = 1'b0;
    send_pkt(32'd1000, 32'd5000, F_ACK, 16'd0);
    @(negedge clk);
    checks++;
    if ({drop_cnt, rx_hdr_rdy, new_flow_val} !== {32'd1, 1'b1, 1'b0}) begin
      errs++; $display("FAIL miss_drop got=%0d %b %b exp=1 1 0",
                       drop_cnt, rx_hdr_rdy, new_flow_val);
    end
    cam_lookup_hit = 1'b1;
    cam_lookup_flowid = 3'd5;
    state_rd_data = mk(32'd1000, 32'd5000, 32'd5000, 13'd0, 13'd0,
                       2'd0, 1'b0);
    send_pkt(32'd1000, 32'd0, F_RST, 16'd0);
    wait_wr(rc, wc);
    checks++;
    if ({wc, flow_close_val, flow_close_flowid, state_wr_val,
         sched_cmd_val} !== {32'd5, 1'b1, 3'd5, 1'b0, 1'b0}) begin
      errs++; $display("FAIL rst_close got=%0d %b %0d %b %b exp=5 1 5 0 0",
                       wc, flow_close_val, flow_close_flowid,
                       state_wr_val, sched_cmd_val);
    end
    send_pkt(32'd999, 32'd0, F_RST, 16'd0);
    wait_wr(rc, wc);
    checks++;
    if ({wc, drop_cnt} !== {32'd0, 32'd2}) begin
      errs++; $display("FAIL rst_oow got=%0d %0d exp=0 2", wc, drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int rc, wc;
    logic [10:0] seen;
    logic [FS_W-1:0] es;
    cam_lookup_hit = 1'b1;
    cam_lookup_flowid = 3'd5;
    state_rd_data = mk(32'd1000, 32'd5000, 32'd5000, 13'd0, 13'd0,
                       2'd0, 1'b0);
    send_pkt(32'd1000, 32'd5000, F_ACK, 16'd100);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      seen = seen | strobes();
      @(negedge clk);
    end
    checks++;
    if ({seen, drop_cnt, rx_hdr_rdy} !== {11'd0, 32'd0, 1'b1}) begin
      errs++; $display("FAIL mid_rst got=%b %0d %b exp=0 0 1",
                       seen, drop_cnt, rx_hdr_rdy);
    end
    send_pkt(32'd1000, 32'd5000, F_ACK, 16'd100);
    wait_wr(rc, wc);
    es = mk(32'd1100, 32'd5000, 32'd5000, 13'd0, 13'd100, 2'd0, 1'b0);
    checks++;
    if ({wc, state_wr_data, pkt_accept_val} !== {32'd5, es, 1'b1}) begin
      errs++; $display("FAIL post_rst got=%0d %h %b exp=5 %h 1",
                       wc, state_wr_data, pkt_accept_val, es);
    end
  endtask

  initial begin
    test_reset();
    test_new_flow();
    test_accept();
    test_reject_wrap();
    test_dupack();
    test_rst_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
